// File: rtl/branch_predictor_pkg.sv
// Shared types and counter encodings for the branch predictor.
package branch_predictor_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        mispredict;
    logic        ds_exc;
  } bp_update_t;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } bp_predict_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'd1;
    end
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Array of 2-bit direction counters: two combinational read ports, one write port.
module bht_table
  import branch_predictor_pkg::*;
#(
  parameter int unsigned Entries = 64,
  parameter int unsigned IdxW    = $clog2(Entries)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [IdxW-1:0] lk_idx_i,
  output logic [1:0]      lk_ctr_o,
  input  logic [IdxW-1:0] up_idx_i,
  output logic [1:0]      up_ctr_o,
  input  logic            we_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [1:0]      wr_ctr_i
);

  logic [1:0] ctr_q [Entries];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Entries); i++) begin
        ctr_q[i] <= WNT;
      end
    end else if (we_i) begin
      ctr_q[wr_idx_i] <= wr_ctr_i;
    end
  end

  assign lk_ctr_o = ctr_q[lk_idx_i];
  assign up_ctr_o = ctr_q[up_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Bimodal direction predictor with a direct-mapped BTB; one-cycle lookup, two-edge update.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lookup_en,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        upd_ds_exc,
  output logic [31:0] mispredict_cnt
);

  localparam int unsigned BhtIdxW = $clog2(BHT_ENTRIES);
  localparam int unsigned BtbIdxW = $clog2(BTB_ENTRIES);
  localparam int unsigned TagW    = 30 - BtbIdxW;

  bp_update_t  u1_q;
  logic        u1_valid_q;
  logic [1:0]  u1_ctr_q;
  bp_predict_t pred_q;
  logic [31:0] cnt_q;

  logic [BhtIdxW-1:0] lk_bidx, up_bidx, u1_bidx;
  logic [BtbIdxW-1:0] lk_tidx, u1_tidx;
  logic [TagW-1:0]    lk_tag, u1_tag;
  logic [1:0]         lk_ctr, up_ctr, up_ctr_fwd, u1_ctr_new;
  logic               upd_accept, u1_aligned, u2_ctr_we, u2_btb_we, lk_hit;

  logic            btb_valid_q  [BTB_ENTRIES];
  logic [TagW-1:0] btb_tag_q    [BTB_ENTRIES];
  logic [31:0]     btb_target_q [BTB_ENTRIES];

  assign lk_bidx = lookup_pc[BhtIdxW+1:2];
  assign lk_tidx = lookup_pc[BtbIdxW+1:2];
  assign lk_tag  = lookup_pc[31:BtbIdxW+2];
  assign up_bidx = upd_pc[BhtIdxW+1:2];
  assign u1_bidx = u1_q.pc[BhtIdxW+1:2];
  assign u1_tidx = u1_q.pc[BtbIdxW+1:2];
  assign u1_tag  = u1_q.pc[31:BtbIdxW+2];

  logic unused_pc;
  assign unused_pc = ^u1_q.pc[1:0];

  assign upd_accept = upd_en & ~upd_ds_exc;
  assign u1_aligned = (u1_q.target[1:0] == 2'b00);
  // A taken branch to a misaligned target is an address-error path; neither table learns it.
  assign u2_ctr_we  = u1_valid_q & ~u1_q.ds_exc & ~(u1_q.taken & ~u1_aligned);
  assign u2_btb_we  = u1_valid_q & ~u1_q.ds_exc & u1_q.taken & u1_aligned;
  assign u1_ctr_new = ctr_next(u1_ctr_q, u1_q.taken);

  // The write in flight this cycle is not yet in the table; forward it so no step is lost.
  assign up_ctr_fwd = (u2_ctr_we && (u1_bidx == up_bidx)) ? u1_ctr_new : up_ctr;

  bht_table #(
    .Entries (BHT_ENTRIES),
    .IdxW    (BhtIdxW)
  ) u_bht (
    .clk_i    (clk),
    .rst_ni   (resetn),
    .lk_idx_i (lk_bidx),
    .lk_ctr_o (lk_ctr),
    .up_idx_i (up_bidx),
    .up_ctr_o (up_ctr),
    .we_i     (u2_ctr_we),
    .wr_idx_i (u1_bidx),
    .wr_ctr_i (u1_ctr_new)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      u1_valid_q <= 1'b0;
      u1_q       <= '0;
      u1_ctr_q   <= WNT;
    end else begin
      u1_valid_q <= upd_accept;
      if (upd_accept) begin
        u1_q     <= '{pc: upd_pc, taken: upd_taken, target: upd_target,
                      mispredict: upd_mispredict, ds_exc: upd_ds_exc};
        u1_ctr_q <= up_ctr_fwd;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (u1_valid_q && !u1_q.ds_exc && u1_q.mispredict) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        btb_valid_q[i] <= 1'b0;
      end
    end else if (u2_btb_we) begin
      btb_valid_q[u1_tidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (u2_btb_we) begin
      btb_tag_q[u1_tidx]    <= u1_tag;
      btb_target_q[u1_tidx] <= u1_q.target;
    end
  end

  assign lk_hit = lk_ctr[1] & btb_valid_q[lk_tidx] & (btb_tag_q[lk_tidx] == lk_tag);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_q <= '0;
    end else begin
      pred_q.valid <= lookup_en;
      if (lookup_en) begin
        pred_q.taken  <= lk_hit;
        pred_q.target <= lk_hit ? btb_target_q[lk_tidx] : lookup_pc + 32'd8;
      end
    end
  end

  assign pred_valid     = pred_q.valid;
  assign pred_taken     = pred_q.taken;
  assign pred_target    = pred_q.target;
  assign mispredict_cnt = cnt_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter BHT_ENTRIES, default 64: number of 2-bit saturating counters.
REQ-002 Parameter BTB_ENTRIES, default 16: number of direct-mapped target entries.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 lookup_en  input  1  fetch stage requests a prediction for lookup_pc.
REQ-006 lookup_pc  input  32  fetch address.
REQ-007 pred_valid  output  1  prediction fields are valid this cycle.
REQ-008 pred_taken  output  1  predicted direction; drives the resolver's branch_taken field.
REQ-009 pred_target  output  32  predicted target; meaningful only when pred_taken is 1.
REQ-010 upd_en  input  1  resolved branch or jump reported from the execute stage.
REQ-011 upd_pc  input  32  PC of the resolved branch.
REQ-012 upd_taken  input  1  actual direction, i.e. the resolver's compare result.
REQ-013 upd_target  input  32  actual taken target (jump_PC).
REQ-014 upd_mispredict  input  1  resolver's branch_predict_fail; used for statistics only.
REQ-015 upd_ds_exc  input  1  delay-slot exception or reserved instruction; the update is discarded.
REQ-016 mispredict_cnt  output  32  count of accepted updates with upd_mispredict=1.

Function
REQ-017 BHT index is pc[log2(BHT_ENTRIES)+1:2]; BTB index is pc[log2(BTB_ENTRIES)+1:2]; BTB tag is pc[31:log2(BTB_ENTRIES)+2].
REQ-018 Lookup latency is one cycle: pred_* is registered, reflecting the lookup_pc sampled on the previous edge when lookup_en was 1.
REQ-019 pred_valid is 1 for exactly the cycle after each accepted lookup and 0 otherwise.
REQ-020 pred_taken = counter[1] AND BTB entry valid AND tag match; otherwise 0 with pred_target = lookup_pc+8.
REQ-021 When pred_taken is 1, pred_target = the stored BTB target.
REQ-022 An update is accepted when upd_en=1 and upd_ds_exc=0.
REQ-023 Accepted update pipeline: stage U1 registers the inputs; stage U2 writes the tables on the following edge. Tables are therefore written two edges after the update is presented.
REQ-024 Counter update saturates: taken increments up to 2'b11; not-taken decrements down to 2'b00.
REQ-025 BTB allocation happens only when upd_taken=1 and upd_target[1:0]=2'b00. Allocation writes the tag and target, sets valid, and overwrites any previous occupant.
REQ-026 A misaligned upd_target never enters the BTB; the AdEL path belongs to the resolver.
REQ-027 A not-taken update never modifies the BTB.
REQ-028 Lookup and U2 write to the same index in the same cycle: the lookup returns the pre-write value (no bypass).
REQ-029 Back-to-back updates to the same index: the second update reads the counter value already written by the first, by forwarding the U2 result into U1, so no increments are lost.
REQ-030 mispredict_cnt increments by 1 per accepted update with upd_mispredict=1 and wraps from 0xFFFF_FFFF to 0.

Reset
REQ-031 On resetn=0, asynchronously:
- all counters set to 2'b01 (weakly not-taken);
- all BTB valid bits cleared;
- pipeline U1/U2 valid flags cleared;
- pred_valid=0, pred_taken=0, pred_target=0, mispredict_cnt=0.
REQ-032 An update in flight in U1 or U2 when reset asserts is discarded.
REQ-033 The first lookup after reset release completes normally.

Structure
REQ-034 The shared package holds:
- a bp_update_t struct (pc, taken, target, mispredict, ds_exc);
- a bp_predict_t struct (valid, taken, target);
- the counter encodings SNT/WNT/WT/ST.
REQ-035 The counter array is a sub-module bht_table (read port, write port, async reset). The BTB is inline.

Verification
REQ-036 Reset, then lookup pc=0xBFC0_0010 -> next cycle pred_valid=1, pred_taken=0, pred_target=0xBFC0_0018.
REQ-037 Two taken updates pc=0xBFC0_0010, target=0xBFC0_0100, then lookup of the same pc -> pred_taken=1, pred_target=0xBFC0_0100.
REQ-038 Four consecutive-cycle not-taken updates to a strongly-taken entry -> counter 2'b00, no lost decrements, then lookup pred_taken=0.
REQ-039 Taken update with upd_target=0xBFC0_0102, or with upd_ds_exc=1 -> BTB and counter unchanged, mispredict_cnt unchanged.
REQ-040 Aliasing pc 0xBFC0_0010 vs 0xBFC0_0050 (same BTB index, different tag): after allocating 0x50, lookup of 0x10 -> pred_taken=0.
REQ-041 resetn pulsed low mid-update -> all counters read back WNT, mispredict_cnt=0, pred_valid=0.
